// File: rtl/dmem_master.sv
// Load/store initiator for the single-port data memory: word-only memory traffic, local sub-word extract/merge.
// Optional misalignment detection is enabled with DMEM_MASTER_MISALIGN_CHECK_EN.
module dmem_master #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_load_control,
  output logic [1:0]        mem_store_control,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W+1:0] addr_r;
  logic [1:0]        size_r;
  logic              we_r;
  logic              uns_r;
  logic [31:0]       wdata_r;
  logic [31:0]       line_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_rdata_r;
  logic              rsp_error_r;
  logic              mis_s;

  // Lane-select and extend a load; size 11 behaves as a word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge store data into the previously read line so neighbouring bytes survive.
  function automatic logic [31:0] store_merge(input logic [31:0] line, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    r = {line[31:8], wdata[7:0]};
          2'd1:    r = {line[31:16], wdata[7:0], line[7:0]};
          2'd2:    r = {line[31:24], wdata[7:0], line[15:0]};
          default: r = {wdata[7:0], line[23:0]};
        endcase
      end
      2'b01:   r = lane[1] ? {wdata[15:0], line[15:0]} : {line[31:16], wdata[15:0]};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Misalignment of the incoming request.
  always_comb begin
    mis_s = 1'b0;
`ifdef DMEM_MASTER_MISALIGN_CHECK_EN
    if (req_size == 2'b01) begin
      mis_s = req_addr[0];
    end else if (req_size[1]) begin
      mis_s = (req_addr[1:0] != 2'b00);
    end else begin
      mis_s = 1'b0;
    end
`endif
  end

  // Request FSM with registered response.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      size_r      <= 2'b00;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      line_r      <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_error_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (req_valid) begin
            addr_r  <= req_addr;
            size_r  <= req_size;
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
            if (mis_s) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_error_r <= 1'b1;
              rsp_rdata_r <= 32'h0000_0000;
            end else if (req_we && req_size[1]) begin
              state_r <= ST_WRITE;
            end else begin
              state_r <= ST_READ;
            end
          end
        end
        ST_READ: begin
          line_r <= mem_rdata;
          if (we_r) begin
            state_r <= ST_WRITE;
          end else begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_error_r <= 1'b0;
            rsp_rdata_r <= load_extract(mem_rdata, addr_r[1:0], size_r, uns_r);
          end
        end
        ST_WRITE: begin
          state_r     <= ST_RESP;
          rsp_valid_r <= 1'b1;
          rsp_error_r <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory controls follow the state alone so reset kills a write at once.
  assign req_ready         = (state_r == ST_IDLE);
  assign mem_load_control  = (state_r == ST_READ)  ? 3'b001 : 3'b000;
  assign mem_store_control = (state_r == ST_WRITE) ? 2'b01  : 2'b00;
  assign mem_address       = addr_r[ADDR_W+1:2];
  assign mem_wdata         = store_merge(line_r, wdata_r, addr_r[1:0], size_r);
  assign rsp_valid         = rsp_valid_r;
  assign rsp_rdata         = rsp_rdata_r;
  assign rsp_error         = rsp_error_r;

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master with a small word memory model; word 5 preloaded per scenario.
module tb_dmem_master;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [16:0] req_addr = 17'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [14:0] mem_address;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_control;
  logic [1:0]  mem_store_control;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        preload = 1'b0;
  int          checks = 0;
  int          failures = 0;

  dmem_master #(.ADDR_W(15)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_load_control(mem_load_control), .mem_store_control(mem_store_control),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_address[5:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 5) ? 32'h8812_34F0 : 32'h0000_0000;
    end else if (mem_store_control == 2'b01) begin
      mem[mem_address[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge clk);
    preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          lw;
    int          sw;
    logic [31:0] w5;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int lat, lw, sw;
    logic [31:0] rd;
    logic        er;
    logic [31:0] held;
    int          seen;

    //            we    size   uns   addr      wdata         rdata         err   lat lw sw w5
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 17'h15, 32'h0,        32'h0000_0034, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 17'h17, 32'h0,        32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 17'h17, 32'h0,        32'h0000_0088, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 17'h16, 32'h0,        32'hFFFF_8812, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 17'h14, 32'h0,        32'h0000_34F0, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 17'h14, 32'h0,        32'h8812_34F0, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[6]  = '{1'b0, 2'b11, 1'b1, 17'h14, 32'h0,        32'h8812_34F0, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 17'h15, 32'hFFFF_FFAB, 32'h0,        1'b0, 3, 1, 1, 32'h8812_ABF0};
    vecs[8]  = '{1'b1, 2'b01, 1'b0, 17'h16, 32'h1234_5566, 32'h0,        1'b0, 3, 1, 1, 32'h5566_34F0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 17'h14, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEAD_BEEF};
`ifdef DMEM_MASTER_MISALIGN_CHECK_EN
    vecs[10] = '{1'b0, 2'b10, 1'b0, 17'h16, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h8812_34F0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 17'h15, 32'h0000_5566, 32'h0,        1'b1, 1, 0, 0, 32'h8812_34F0};
`else
    vecs[10] = '{1'b0, 2'b10, 1'b0, 17'h16, 32'h0,        32'h8812_34F0, 1'b0, 2, 1, 0, 32'h8812_34F0};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 17'h15, 32'h0000_5566, 32'h0,        1'b0, 3, 1, 1, 32'h8812_5566};
`endif
    vecs[12] = '{1'b0, 2'b00, 1'b0, 17'h14, 32'h0,        32'hFFFF_FFF0, 1'b0, 2, 1, 0, 32'h8812_34F0};

    // Reset state
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
    chk("rst_load_ctl", {29'h0, mem_load_control}, 32'h0);
    chk("rst_store_ctl", {30'h0, mem_store_control}, 32'h0);
    chk("rst_mem_addr", {17'h0, mem_address}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    nreset = 1'b1;

    for (int v = 0; v < 13; v++) begin
      do_preload();
      @(negedge clk);
      chk($sformatf("v%0d_ready", v), {31'h0, req_ready}, 32'h1);
      req_we = vecs[v].we; req_size = vecs[v].size; req_unsigned = vecs[v].uns;
      req_addr = vecs[v].addr; req_wdata = vecs[v].wdata; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = ~vecs[v].we; req_size = ~vecs[v].size;
      req_unsigned = ~vecs[v].uns; req_addr = 17'h1FFFF; req_wdata = 32'hFFFF_FFFF;
      lat = -1; lw = 0; sw = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (mem_load_control == 3'b001) lw++;
        if (mem_store_control == 2'b01) sw++;
        if (rsp_valid) begin
          lat = c; rd = rsp_rdata; er = rsp_error;
          break;
        end
      end
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].rdata);
      chk($sformatf("v%0d_error", v), {31'h0, er}, {31'h0, vecs[v].err});
      chk($sformatf("v%0d_lw_cycles", v), lw, vecs[v].lw);
      chk($sformatf("v%0d_sw_cycles", v), sw, vecs[v].sw);
      chk($sformatf("v%0d_word5", v), mem[5], vecs[v].w5);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_once", v), {31'h0, rsp_valid}, 32'h0);
      chk($sformatf("v%0d_ready_after", v), {31'h0, req_ready}, 32'h1);
      chk($sformatf("v%0d_rdata_hold", v), rsp_rdata, vecs[v].rdata);
    end

    // Reset during the WRITE state of a half store
    do_preload();
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 17'h16; req_wdata = 32'h0000_5566; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (mem_store_control == 2'b01) begin
        seen = 1;
        break;
      end
    end
    chk("rstw_reached_write", seen, 1);
    #2 nreset = 1'b0;
    #1;
    chk("rstw_store_ctl_drop", {30'h0, mem_store_control}, 32'h0);
    chk("rstw_ready_in_reset", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_word5_kept", mem[5], 32'h8812_34F0);
    nreset = 1'b1;
    held = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) held = held + 32'h1;
    end
    chk("rstw_no_rsp", held, 32'h0);
    chk("rstw_ready_after", {31'h0, req_ready}, 32'h1);
    chk("rstw_word5_final", mem[5], 32'h8812_34F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_master.md
# dmem_master

Load/store initiator that drives the single-port data memory from the core's memory stage. It accepts one byte/half/word request at a time over a valid/ready handshake and issues only word reads (LW) and word writes (SW) to memory. Sub-word loads are lane-selected and sign- or zero-extended locally. Sub-word stores use read-modify-write so that neighbouring bytes are preserved, because the memory's native SH/SB zero the upper bits.

## Interface

Parameters:
- ADDR_W, 15, word-address width toward memory; byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_unsigned  in  1  zero-extend sub-word loads; ignored for words and stores.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, registered; 0 for stores and errors.
- rsp_error  out  1  misaligned request, qualified by rsp_valid.
- mem_address  out  ADDR_W  word address, equal to latched req_addr[ADDR_W+1:2].
- mem_wdata  out  32  merged write word.
- mem_load_control  out  3  001 in READ, 000 otherwise.
- mem_store_control  out  2  01 in WRITE, 00 otherwise.
- mem_rdata  in  32  combinational read data from memory.

## Operation

- FSM states: IDLE, READ, WRITE, RESP. Memory controls decode combinationally from state only.
- IDLE: req_ready=1. On req_valid, latch addr, size, we, unsigned and wdata. Next state:
  - misaligned → RESP with error. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - word store → WRITE.
  - any load or sub-word store → READ.
- READ: drive LW. At the clock edge, capture mem_rdata into a 32-bit line register. Next state is WRITE for a store, RESP for a load.
- WRITE: drive SW with mem_wdata.
  - Word store: mem_wdata = latched wdata.
  - Byte store: line register with byte k = addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - Half store: line register with half h = addr[1] (bits 16h+15:16h) replaced by wdata[15:0].
  - Next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_error are registered on entry. Next state is IDLE.
- Load data formation:
  - Byte: field from lane k, extended with field[7] when signed, zeros when unsigned.
  - Half: field from lane h, extended with field[15] or zeros.
  - Word: passed through unchanged.
- rsp_rdata holds its value between responses.
- No back-to-back acceptance: the minimum spacing between accepts is one IDLE cycle after RESP.

## Timing

Latency is counted from the acceptance edge (the edge where req_valid and req_ready are both 1) to the cycle in which rsp_valid is high:
- error: 1 cycle.
- word store: 2 cycles.
- load: 2 cycles.
- sub-word store: 3 cycles.

Memory activity:
- Exactly one SW cycle per store.
- Zero memory cycles for errors.
- A word store issues no LW.

Reset values:
- State IDLE, so req_ready=1 while nreset=0.
- rsp_valid=0, rsp_rdata=0, rsp_error=0.
- mem_load_control=000, mem_store_control=00.
- mem_address=0, mem_wdata=0, line register 0.

Reset mid-operation:
- Asserting nreset during WRITE drops mem_store_control to 00 immediately, so no write commits at the next edge.
- The in-flight request is discarded and no rsp_valid is produced.

req_* inputs are sampled only at acceptance; changes to them in other states are ignored.

## Configuration

- DMEM_MASTER_MISALIGN_CHECK_EN defined: misalignment detection and rsp_error are implemented as described above.
- DMEM_MASTER_MISALIGN_CHECK_EN undefined:
  - rsp_error is tied to 0.
  - Misaligned halves use lane addr[1] and misaligned words ignore addr[1:0].
  - Every request performs its normal memory sequence.

## Test plan

Memory word 5 is preloaded with 0x881234F0 before each scenario.

- Byte loads: signed LB at 0x15 → rsp_rdata 0x00000034; signed LB at 0x17 → 0xFFFFFF88; LBU at 0x17 → 0x00000088. In each case rsp_valid comes 2 cycles after accept and one LW cycle is issued.
- Half loads: signed LH at 0x16 → 0xFFFF8812; LHU at 0x14 → 0x000034F0.
- Sub-word stores:
  - SB of 0xAB at 0x15 → word 5 = 0x8812ABF0. Exactly one READ cycle, then one cycle with mem_store_control=01; rsp_valid 3 cycles after accept.
  - SH of 0x5566 at 0x16 → word 5 = 0x556634F0.
- Word store: SW of 0xDEADBEEF at 0x14 → word 5 = 0xDEADBEEF, no LW cycle, rsp_valid 2 cycles after accept, rsp_rdata=0.
- Misaligned LW at 0x16:
  - Macro defined: rsp_valid with rsp_error=1 one cycle after accept, no memory controls asserted.
  - Macro undefined: rsp_rdata=0x881234F0, rsp_error=0.
- Reset during the WRITE state of a SH: mem_store_control goes to 00 immediately, word 5 remains 0x881234F0, no rsp_valid, and req_ready=1 after reset release.
